shuffle_addr_gen: RTL and testbench

- Upstream sequencer for the NTT/INTT shuffled-address ROM.
- Walks 7 layers × 32 butterfly slots, starting each layer at a random rotation offset, and drives the 8-bit ROM index {layer, slot}.
- Registers the returned 6-bit shuffled address and presents it to the butterfly controller over a valid/ready handshake.
- Side-channel countermeasure: butterfly processing order changes per run.

---
 rtl/shuffle_addr_gen.sv | 95 +++++++++
 tb/tb_shuffle_addr_gen.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/shuffle_addr_gen.sv
// shuffle_addr_gen: walks NTT/INTT layers x slots with a per-layer rotation and registers the ROM's shuffled address.
// Optional macro SHUFFLE_RAND_EN: take one random rotation offset per layer (otherwise offset is 0, no SEED stall).
module shuffle_addr_gen #(
    parameter int NUM_LAYERS  = 7,
    parameter int LAYER_SLOTS = 32,
    parameter int OUT_W       = 6,
    localparam int LW = $clog2(NUM_LAYERS),
    localparam int SW = $clog2(LAYER_SLOTS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             inverse,
    input  logic             rand_valid,
    input  logic [SW-1:0]    rand_data,
    output logic             rand_ready,
    output logic [LW+SW-1:0] rom_old_addr,
    input  logic [OUT_W-1:0] rom_new_addr,
    output logic             addr_valid,
    input  logic             addr_ready,
    output logic [OUT_W-1:0] addr_out,
    output logic [LW-1:0]    addr_layer,
    output logic             addr_last,
    output logic             busy,
    output logic             done
);
    typedef enum logic [2:0] {IDLE, SEED, ISSUE, DRAIN, FIN} state_t;
    state_t state, state_nxt;
    logic inv;
    logic [LW-1:0] layer;
    logic [SW-1:0] idx, offset;
    logic load, last_slot, final_layer, hs;
`ifdef SHUFFLE_RAND_EN
    localparam state_t ENTRY = SEED;
    assign rand_ready = state == SEED;
    always_ff @(posedge clk or posedge rst)
        if (rst) offset <= '0;
        else if (state == SEED && rand_valid) offset <= rand_data;
`else
    localparam state_t ENTRY = ISSUE;
    logic unused_rand;
    assign unused_rand = rand_valid ^ (^rand_data);
    assign rand_ready = 1'b0;
    assign offset = '0;
`endif
    assign hs = addr_valid & addr_ready;
    assign load = state == ISSUE && (!addr_valid || addr_ready);
    assign last_slot = idx == SW'(LAYER_SLOTS - 1);
    assign final_layer = inv ? layer == '0 : layer == LW'(NUM_LAYERS - 1);
    // the 5-bit sum wraps, rotating the slot order within a layer
    assign rom_old_addr = {layer, offset + idx};
    assign busy = state != IDLE;
    assign done = state == FIN;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ENTRY;
            SEED:    if (rand_valid) state_nxt = ISSUE;
            ISSUE:   if (load && last_slot) state_nxt = final_layer ? DRAIN : ENTRY;
            DRAIN:   if (hs) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            inv        <= 1'b0;
            layer      <= '0;
            idx        <= '0;
            addr_valid <= 1'b0;
            addr_out   <= '0;
            addr_layer <= '0;
            addr_last  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                inv   <= inverse;
                layer <= inverse ? LW'(NUM_LAYERS - 1) : '0;
                idx   <= '0;
            end
            // a load may coincide with a handshake, giving one address per cycle
            if (load) begin
                addr_out   <= rom_new_addr;
                addr_layer <= layer;
                addr_valid <= 1'b1;
                addr_last  <= final_layer && last_slot;
                idx        <= idx + 1'b1;
                if (last_slot && !final_layer) layer <= inv ? layer - 1'b1 : layer + 1'b1;
            end else if (hs) begin
                addr_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_shuffle_addr_gen.sv
// tb_shuffle_addr_gen: directed runs checked every cycle against a queue model of the expected address stream.
module tb_shuffle_addr_gen;
    logic clk = 0, rst = 1, start = 0, inverse = 0, rand_valid = 0, addr_ready = 1;
    logic [4:0] rand_data = 0;
    logic rand_ready, addr_valid, addr_last, busy, done;
    logic [7:0] rom_old_addr;
    logic [5:0] rom_new_addr, addr_out;
    logic [2:0] addr_layer;

    always #5 clk = ~clk;

`ifdef SHUFFLE_RAND_EN
    localparam bit RAND = 1'b1;
    localparam int LAT = 3;
`else
    localparam bit RAND = 1'b0;
    localparam int LAT = 2;
`endif

    logic [5:0] rom [256];
    assign rom_new_addr = rom[rom_old_addr];

    shuffle_addr_gen dut (
        .clk(clk), .rst(rst), .start(start), .inverse(inverse),
        .rand_valid(rand_valid), .rand_data(rand_data), .rand_ready(rand_ready),
        .rom_old_addr(rom_old_addr), .rom_new_addr(rom_new_addr),
        .addr_valid(addr_valid), .addr_ready(addr_ready), .addr_out(addr_out),
        .addr_layer(addr_layer), .addr_last(addr_last), .busy(busy), .done(done)
    );

    typedef struct packed {logic [5:0] a; logic [2:0] l; logic last;} exp_t;
    exp_t exp_q[$];
    int got_a[$], got_l[$];
    int offs[7];
    int ptr, checks, failures, hs_cnt, lat;
    bit rand_gap, xfer, run_on, done_due;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    function automatic int ga(input int i);
        return got_a.size() > i ? got_a[i] : -1;
    endfunction

    function automatic int gl(input int i);
        return got_l.size() > i ? got_l[i] : -1;
    endfunction

    // expected stream: layers in walk order, each rotated by its offset
    task automatic build_model(input bit inv);
        exp_t e;
        exp_q.delete();
        for (int k = 0; k < 7; k++) begin
            automatic int ly = inv ? 6 - k : k;
            automatic int off = RAND ? offs[k] : 0;
            for (int j = 0; j < 32; j++) begin
                e.a = rom[ly * 32 + (off + j) % 32];
                e.l = 3'(ly);
                e.last = k == 6 && j == 31;
                exp_q.push_back(e);
            end
        end
    endtask

    always @(negedge clk) xfer = rand_valid & rand_ready;

    initial forever begin
        @(posedge clk); #1;
        if (xfer) ptr++;
        rand_valid = RAND && (!rand_gap || $urandom_range(0, 1) == 1);
        rand_data = 5'(offs[ptr % 7]);
    end

    always @(negedge clk) begin
        if (rst) begin
            check("reset_outputs", {rand_ready, addr_valid, addr_out, addr_layer, addr_last, busy, done}, 0);
            exp_q.delete();
            run_on = 0;
            done_due = 0;
        end else begin
            check("done", done, done_due);
            check("busy", busy, run_on);
            if (done_due) run_on = 0;
            done_due = 0;
            if (addr_valid) begin
                if (exp_q.size() == 0) check("unexpected_valid", addr_valid, 0);
                else begin
                    check("addr_out", addr_out, exp_q[0].a);
                    check("addr_layer", addr_layer, exp_q[0].l);
                    check("addr_last", addr_last, exp_q[0].last);
                    if (addr_ready) begin
                        got_a.push_back(int'(addr_out));
                        got_l.push_back(int'(addr_layer));
                        hs_cnt++;
                        void'(exp_q.pop_front());
                        if (exp_q.size() == 0) done_due = 1;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic start_run(input bit inv);
        build_model(inv);
        got_a.delete();
        got_l.delete();
        hs_cnt = 0;
        ptr = 0;
        start = 1;
        inverse = inv;
        tick();
        start = 0;
        inverse = 0;
        run_on = 1;
    endtask

    task automatic wait_hs(input int n);
        for (int c = 0; c < 2000 && hs_cnt < n; c++) tick();
        check("wait_hs", hs_cnt >= n, 1);
    endtask

    task automatic finish_run();
        for (int c = 0; c < 3000 && run_on; c++) tick();
        check("run_end", run_on, 0);
        check("hs_total", hs_cnt, 224);
        check("model_empty", exp_q.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 6'((i * 37 + 11) % 64);
        rom[0] = 1; rom[1] = 9; rom[2] = 28; rom[3] = 30; rom[4] = 31;
        rom[5] = 14; rom[6] = 7; rom[7] = 2;
        rom[31] = 18; rom[32] = 3; rom[33] = 6; rom[192] = 32;
        offs = '{default: 0};
        rand_gap = 0;
        repeat (2) tick();
        rst = 0;
        tick();

        // forward, offset 0, full throughput, stray start mid-run
        start_run(0);
        lat = 1;
        while (!addr_valid && lat < 20) begin tick(); lat++; end
        check("first_valid_latency", lat, LAT);
        wait_hs(50);
        start = 1; inverse = 1;
        tick();
        start = 0; inverse = 0;
        finish_run();
        check("fwd_a0", ga(0), 1);
        check("fwd_a1", ga(1), 9);
        check("fwd_a2", ga(2), 28);
        check("fwd_a3", ga(3), 30);
        check("fwd_a4", ga(4), 31);
        check("fwd_a31", ga(31), 18);
        check("fwd_a32", ga(32), 3);
        check("fwd_a33", ga(33), 6);
        check("fwd_last_layer", gl(223), 6);
        repeat (3) tick();

`ifdef SHUFFLE_RAND_EN
        // random offsets with rand_valid gaps
        offs = '{5, 17, 0, 31, 9, 22, 3};
        rand_gap = 1;
        start_run(0);
        finish_run();
        check("rand_a0", ga(0), 14);
        check("rand_a1", ga(1), 7);
        check("rand_a2", ga(2), 2);
        check("rand_idx31", ga(26), 18);
        check("rand_wrap_idx0", ga(27), 1);
        offs = '{default: 0};
        repeat (3) tick();
`endif

        // inverse walk
        start_run(1);
        finish_run();
        check("inv_a0", ga(0), 32);
        check("inv_l0", gl(0), 6);
        check("inv_last_a", ga(223), 18);
        check("inv_last_l", gl(223), 0);
        rand_gap = 0;
        repeat (3) tick();

        // backpressure on the first address
        addr_ready = 0;
        start_run(0);
        for (int c = 0; c < 50 && !addr_valid; c++) tick();
        for (int c = 0; c < 3; c++) begin
            check("bp_hold_out", addr_out, 1);
            check("bp_hold_idx", rom_old_addr, 1);
            tick();
        end
        addr_ready = 1;
        finish_run();
        check("bp_a0", ga(0), 1);
        check("bp_a1", ga(1), 9);
        repeat (3) tick();

        // reset after the 40th handshake, then a fresh run
        start_run(0);
        wait_hs(40);
        rst = 1;
        #1;
        check("midrst_outputs", {rand_ready, addr_valid, addr_out, addr_layer, addr_last, busy, done}, 0);
        tick();
        rst = 0;
        repeat (4) tick();
        start_run(0);
        finish_run();
        check("restart_a0", ga(0), 1);
        check("restart_l0", gl(0), 0);
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
